// File: rtl/ycr1_arch_types_pkg.sv
// Shared architectural constants and types for the ycr1 pipeline.
// Holds the default register-file geometry and the widest register address type.
package ycr1_arch_types_pkg;

    localparam int unsigned YCR1_XLEN        = 32;
    localparam int unsigned YCR1_MPRF_NREGS  = 32;
    localparam int unsigned YCR1_MPRF_AW_MAX = 5;

    typedef logic [YCR1_MPRF_AW_MAX-1:0] type_ycr1_mprf_addr_v;

endpackage : ycr1_arch_types_pkg

// File: rtl/ycr1_mprf_sb.sv
// Register scoreboard: one pending bit per architectural register.
// A lock sets the bit, a write clears it, and a same-cycle lock beats the write.
module ycr1_mprf_sb
    import ycr1_arch_types_pkg::*;
#(
    parameter int NREGS = YCR1_MPRF_NREGS,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lock_req_i,
    input  logic [AW-1:0]     lock_addr_i,
    input  logic [NWR-1:0]    wr_req_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    output logic [NREGS-1:0]  pend_o,
    output logic [NREGS-1:0]  pend_next_o
);

    logic [NREGS-1:0] pend_q;

    // NOTE: combinational blocks use blocking '=' and start from a full default so no latch is inferred.
    always_comb begin
        pend_next_o = pend_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_req_i[j]) begin
                pend_next_o[wr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (lock_req_i) begin
            pend_next_o[lock_addr_i] = 1'b1;
        end
        pend_next_o[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_next_o;
        end
    end

    assign pend_o = pend_q;

endmodule : ycr1_mprf_sb

// File: rtl/ycr1_pipe_mprf_mp.sv
// Multi-ported register file with per-register scoreboard.
// RD_STAGE selects asynchronous reads or one-cycle registered reads with write-first bypass.
module ycr1_pipe_mprf_mp
    import ycr1_arch_types_pkg::*;
#(
    parameter int XLEN     = YCR1_XLEN,
    parameter int NREGS    = YCR1_MPRF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int RD_STAGE = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic [NWR-1:0]      wr_req_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    input  logic                lock_req_i,
    input  logic [AW-1:0]       lock_addr_i
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // NOTE: the array is reset explicitly because every register must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // Ascending port order: the last assignment, i.e. the highest port, wins.
            for (int j = 0; j < NWR; j++) begin
                if (wr_req_i[j] && (wr_addr_i[j*AW +: AW] != '0)) begin
                    regs_q[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
                end
            end
        end
    end

    ycr1_mprf_sb #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) i_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lock_req_i  (lock_req_i),
        .lock_addr_i (lock_addr_i),
        .wr_req_i    (wr_req_i),
        .wr_addr_i   (wr_addr_i),
        .pend_o      (pend_q),
        .pend_next_o (pend_d)
    );

    generate
        if (RD_STAGE == 0) begin : g_async
            logic [NREGS-1:0] pend_d_unused;
            assign pend_d_unused = pend_d;

            for (genvar k = 0; k < NRD; k++) begin : g_port
                assign rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
                assign rd_busy_o[k]              = pend_q[rd_addr_i[k*AW +: AW]];
            end
        end else begin : g_sync
            for (genvar k = 0; k < NRD; k++) begin : g_port
                logic [AW-1:0]   ra;
                logic [XLEN-1:0] rd_fwd;
                logic [XLEN-1:0] rd_data_q;
                logic            rd_busy_q;

                assign ra = rd_addr_i[k*AW +: AW];

                // Write-first: a same-cycle write to the read address overrides the array.
                always_comb begin
                    rd_fwd = regs_q[ra];
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_req_i[j] && (ra != '0) && (wr_addr_i[j*AW +: AW] == ra)) begin
                            rd_fwd = wr_data_i[j*XLEN +: XLEN];
                        end
                    end
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        rd_data_q <= '0;
                        rd_busy_q <= 1'b0;
                    end else begin
                        rd_data_q <= rd_fwd;
                        rd_busy_q <= pend_d[ra];
                    end
                end

                assign rd_data_o[k*XLEN +: XLEN] = rd_data_q;
                assign rd_busy_o[k]              = rd_busy_q;
            end
        end
    endgenerate

`ifdef YCR1_TRGT_SIMULATION
    param_legal : assert property (@(posedge clk)
        ((NREGS == 16) || (NREGS == 32)) && (NRD >= 1) && (NRD <= 4) && (NWR >= 1) && (NWR <= 2))
        else $error("ycr1_pipe_mprf_mp: illegal parameter set");

    always @(posedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_req_i[j] && ($isunknown(wr_addr_i[j*AW +: AW]) || $isunknown(wr_data_i[j*XLEN +: XLEN]))) begin
                    $error("ycr1_pipe_mprf_mp: X on write port %0d", j);
                end
            end
        end
    end
`endif

endmodule : ycr1_pipe_mprf_mp

// File: tb/tb_ycr1_pipe_mprf_mp.sv
// Self-checking bench: directed vector table, reset/bypass sequences and randomized
// traffic on a registered-read instance and an asynchronous-read instance.
module tb_ycr1_pipe_mprf_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: defaults (32 regs, 2 read, 2 write, registered read)
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_busy;
    logic [1:0]  a_wr_req;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic        a_lock;
    logic [4:0]  a_lock_addr;

    // Instance B: 16 regs, 4 read, 1 write, asynchronous read
    logic [15:0]  b_rd_addr;
    logic [127:0] b_rd_data;
    logic [3:0]   b_busy;
    logic [0:0]   b_wr_req;
    logic [3:0]   b_wr_addr;
    logic [31:0]  b_wr_data;
    logic         b_lock;
    logic [3:0]   b_lock_addr;

    ycr1_pipe_mprf_mp u_dut_a (
        .clk (clk), .rst_n (rst_n),
        .rd_addr_i (a_rd_addr), .rd_data_o (a_rd_data), .rd_busy_o (a_busy),
        .wr_req_i (a_wr_req), .wr_addr_i (a_wr_addr), .wr_data_i (a_wr_data),
        .lock_req_i (a_lock), .lock_addr_i (a_lock_addr)
    );

    ycr1_pipe_mprf_mp #(.XLEN(32), .NREGS(16), .NRD(4), .NWR(1), .RD_STAGE(0)) u_dut_b (
        .clk (clk), .rst_n (rst_n),
        .rd_addr_i (b_rd_addr), .rd_data_o (b_rd_data), .rd_busy_o (b_busy),
        .wr_req_i (b_wr_req), .wr_addr_i (b_wr_addr), .wr_data_i (b_wr_data),
        .lock_req_i (b_lock), .lock_addr_i (b_lock_addr)
    );

    // Reference model: plain architectural state
    logic [31:0] ma_regs [32];
    logic [31:0] ma_pend;
    logic [31:0] mb_regs [16];
    logic [15:0] mb_pend;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) ma_regs[i] = '0;
        for (int i = 0; i < 16; i++) mb_regs[i] = '0;
        ma_pend = '0;
        mb_pend = '0;
    endtask

    // Architectural rule: writes land in port order (last wins), then locks set busy,
    // and register 0 never changes.
    task automatic model_update();
        for (int j = 0; j < 2; j++) begin
            if (a_wr_req[j] && a_wr_addr[j*5 +: 5] != 0) begin
                ma_regs[a_wr_addr[j*5 +: 5]] = a_wr_data[j*32 +: 32];
                ma_pend[a_wr_addr[j*5 +: 5]] = 1'b0;
            end
        end
        if (a_lock && a_lock_addr != 0) ma_pend[a_lock_addr] = 1'b1;
        if (b_wr_req[0] && b_wr_addr != 0) begin
            mb_regs[b_wr_addr] = b_wr_data;
            mb_pend[b_wr_addr] = 1'b0;
        end
        if (b_lock && b_lock_addr != 0) mb_pend[b_lock_addr] = 1'b1;
    endtask

    task automatic idle_inputs();
        a_rd_addr = '0; a_wr_req = '0; a_wr_addr = '0; a_wr_data = '0;
        a_lock = 1'b0; a_lock_addr = '0;
        b_rd_addr = '0; b_wr_req = '0; b_wr_addr = '0; b_wr_data = '0;
        b_lock = 1'b0; b_lock_addr = '0;
    endtask

    // One clock: check B combinationally before the edge, A one cycle later against
    // the post-edge model at the addresses presented this cycle.
    task automatic step();
        logic [4:0] ra [2];
        #2;
        for (int k = 0; k < 4; k++) begin
            check("b_rd_data", b_rd_data[k*32 +: 32], mb_regs[b_rd_addr[k*4 +: 4]]);
            check("b_rd_busy", {31'd0, b_busy[k]}, {31'd0, mb_pend[b_rd_addr[k*4 +: 4]]});
        end
        for (int k = 0; k < 2; k++) ra[k] = a_rd_addr[k*5 +: 5];
        @(posedge clk);
        model_update();
        #1;
        for (int k = 0; k < 2; k++) begin
            check("a_rd_data", a_rd_data[k*32 +: 32], ma_regs[ra[k]]);
            check("a_rd_busy", {31'd0, a_busy[k]}, {31'd0, ma_pend[ra[k]]});
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        lk;
        logic [4:0]  la;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // we,   wa0, wd0,          wa1, wd1,          lk,  la, ra0, ra1, d0,           d1,           b0, b1
        vecs[0] = '{2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 5'd3, 32'h00000001, 5'd3, 32'h00000002, 1'b0, 5'd0, 5'd3, 5'd7, 32'h00000002, 32'h12345678, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        32'h00000002, 1'b0, 1'b0};
        vecs[3] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd0, 32'h0,        32'h0,        1'b1, 1'b0};
        vecs[4] = '{2'b10, 5'd0, 32'h0,        5'd9, 32'h000000AA, 1'b0, 5'd0, 5'd9, 5'd7, 32'h000000AA, 32'h12345678, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 5'd9, 32'h000000BB, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 32'h000000BB, 32'h000000BB, 1'b1, 1'b1};
        vecs[6] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd3, 32'h000000BB, 32'h00000002, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 5'd0, 32'h0,        5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd3, 5'd5, 32'h00000002, 32'hDEADBEEF, 1'b0, 1'b0};

        idle_inputs();
        model_clear();
        rst_n = 1'b0;
        #12;
        check("reset_a_data0", a_rd_data[31:0], 32'h0);
        check("reset_a_data1", a_rd_data[63:32], 32'h0);
        check("reset_a_busy", {30'd0, a_busy}, 32'h0);
        check("reset_b_busy", {28'd0, b_busy}, 32'h0);
        #11;
        rst_n = 1'b1;

        // Directed vector table on instance A
        for (int i = 0; i < 8; i++) begin
            a_wr_req = vecs[i].we;
            a_wr_addr = {vecs[i].wa1, vecs[i].wa0};
            a_wr_data = {vecs[i].wd1, vecs[i].wd0};
            a_lock = vecs[i].lk;
            a_lock_addr = vecs[i].la;
            a_rd_addr = {vecs[i].ra1, vecs[i].ra0};
            step();
            check($sformatf("vec%0d_d0", i), a_rd_data[31:0], vecs[i].d0);
            check($sformatf("vec%0d_d1", i), a_rd_data[63:32], vecs[i].d1);
            check($sformatf("vec%0d_b0", i), {31'd0, a_busy[0]}, {31'd0, vecs[i].b0});
            check($sformatf("vec%0d_b1", i), {31'd0, a_busy[1]}, {31'd0, vecs[i].b1});
        end

        // Asynchronous-read instance: a same-cycle write is not visible until after the edge
        idle_inputs();
        b_wr_req = 1'b1; b_wr_addr = 4'd7; b_wr_data = 32'h55AA55AA; b_rd_addr = {4'd0, 4'd0, 4'd7, 4'd7};
        #2;
        check("b_same_cycle_old", b_rd_data[31:0], 32'h0);
        @(posedge clk);
        model_update();
        #1;
        check("b_next_cycle_new", b_rd_data[31:0], 32'h55AA55AA);
        check("b_ports_agree", b_rd_data[63:32], 32'h55AA55AA);

        // Reset mid-run while a write and a lock are requested
        idle_inputs();
        a_wr_req = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'hCAFEF00D};
        a_lock = 1'b1; a_lock_addr = 5'd9;
        rst_n = 1'b0;
        #1;
        check("midrst_a_data1", a_rd_data[63:32], 32'h0);
        check("midrst_a_busy", {30'd0, a_busy}, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle_inputs();
        model_clear();
        a_rd_addr = {5'd9, 5'd5};
        step();
        check("post_rst_x5", a_rd_data[31:0], 32'h0);
        check("post_rst_x9_busy", {30'd0, a_busy}, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic narrow;
            narrow = ($urandom_range(0, 1) == 1);
            a_wr_req = 2'($urandom);
            for (int j = 0; j < 2; j++) begin
                a_wr_addr[j*5 +: 5] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                a_wr_data[j*32 +: 32] = $urandom;
                a_rd_addr[j*5 +: 5] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            a_lock = ($urandom_range(0, 3) == 0);
            a_lock_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            b_wr_req = 1'($urandom);
            b_wr_addr = 4'($urandom_range(0, 15));
            b_wr_data = $urandom;
            b_lock = ($urandom_range(0, 3) == 0);
            b_lock_addr = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) b_rd_addr[k*4 +: 4] = 4'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ycr1_pipe_mprf_mp

// File: doc/ycr1_pipe_mprf_mp.md
YCR1_PIPE_MPRF_MP -- requirements
Module: ycr1_pipe_mprf_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; legal values 16 or 32; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, read port count; legal range 1..4.
REQ-004 SHALL have parameter NWR, default 2, write port count; legal range 1..2.
REQ-005 SHALL have parameter RD_STAGE, default 1; 0 = asynchronous read, 1 = registered read with write-first bypass.
REQ-006 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-008 SHALL have port rd_addr_i, input, NRD*AW bits, packed read addresses; port k occupies slice k.
REQ-009 SHALL have port rd_data_o, output, NRD*XLEN bits, packed read data.
REQ-010 SHALL have port rd_busy_o, output, NRD bits, per-port scoreboard-pending flag.
REQ-011 SHALL have port wr_req_i, input, NWR bits, per-port write strobe.
REQ-012 SHALL have port wr_addr_i, input, NWR*AW bits, packed write addresses.
REQ-013 SHALL have port wr_data_i, input, NWR*XLEN bits, packed write data.
REQ-014 SHALL have port lock_req_i, input, 1 bit, marks a destination register as pending.
REQ-015 SHALL have port lock_addr_i, input, AW bits, address to lock.

Function
REQ-016 Register 0 SHALL read as zero; writes and locks to address 0 SHALL be ignored.
REQ-017 A write with wr_req_i[j]=1 and nonzero address SHALL update the array at the rising edge.
REQ-018 When two write ports target the same address in one cycle, the higher port index SHALL win.
REQ-019 RD_STAGE=0: rd_data_o[k] SHALL equal the array contents at rd_addr_i[k] combinationally, with no bypass; same-cycle writes appear next cycle.
REQ-020 RD_STAGE=1: rd_data_o[k] in cycle N+1 SHALL equal the value written at edge N if any port wrote rd_addr_i[k] in cycle N (subject to REQ-018); otherwise it SHALL equal the array value sampled at edge N. Latency is one cycle.
REQ-021 The scoreboard SHALL hold one pending bit per register (bit 0 always 0).
REQ-022 lock_req_i SHALL set the bit at lock_addr_i at the edge; a valid write SHALL clear the bit at its address.
REQ-023 A lock and a write to the same address in one cycle SHALL leave the bit set (lock wins).
REQ-024 RD_STAGE=0: rd_busy_o[k] SHALL be the current pending bit of rd_addr_i[k]. RD_STAGE=1: rd_busy_o[k] SHALL be registered and cycle-aligned with rd_data_o[k], reflecting the post-edge-N scoreboard.
REQ-025 Read ports SHALL be independent; identical addresses on several ports SHALL return identical data.

Reset
REQ-026 rst_n low SHALL asynchronously clear all registers, all scoreboard bits, rd_data_o and rd_busy_o to 0.
REQ-027 Writes and locks asserted during reset SHALL be discarded; the first update SHALL occur at the first rising edge after rst_n rises.

Structure
REQ-028 Shared constants (default XLEN/NREGS) and an address typedef SHALL live in the existing ycr1 arch types package; the module SHALL define no new global typedef.
REQ-029 One sub-module, ycr1_mprf_sb (scoreboard, REQ-021..023), SHALL be instantiated; read and write muxing SHALL stay in the top.
REQ-030 Parameter legality (REQ-002..004) SHALL be checked by a simulation-only assertion under YCR1_TRGT_SIMULATION; a write with X on address/data while wr_req_i=1 SHALL raise $error.

Verification
REQ-031 Reset mid-run: write x5=0xDEADBEEF, pulse rst_n low -> read x5 returns 0, all rd_busy_o=0.
REQ-032 x0 guard: write x0=0xFFFFFFFF and lock x0 -> read x0 returns 0, rd_busy_o=0.
REQ-033 Bypass (RD_STAGE=1): in one cycle, write x7=0x12345678 and read x7 on port 0 -> next cycle rd_data_o[0]=0x12345678. With RD_STAGE=0, same-cycle read returns the old value.
REQ-034 Write collision: port0 writes x3=0x1, port1 writes x3=0x2 in the same cycle -> x3 reads 0x2.
REQ-035 Scoreboard: lock x9 -> rd_busy for x9=1; write x9 -> busy=0; lock and write x9 in the same cycle -> busy stays 1.
REQ-036 Random regression: 10k cycles, all parameter corners (NREGS 16/32, NRD 1..4, NWR 1..2, RD_STAGE 0/1), checked against a reference model with zero mismatches.
